// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: PC-mux select
// encodings, sequencer states and the source-extension addressing rule.
package pc_fetch_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXT   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [2:0] MPC_HOLD    = 3'd0;
   localparam logic [2:0] MPC_INC     = 3'd1;
   localparam logic [2:0] MPC_CALC    = 3'd2;
   localparam logic [2:0] MPC_MDB_SHL = 3'd3;
   localparam logic [2:0] MPC_MDB     = 3'd4;

   // A source operand needs an extension word for indexed/absolute/symbolic
   // mode (As=01, except the constant generator R3) and for immediate (@PC+).
   function automatic logic src_ext_rule(input logic [1:0] as_f,
                                         input logic [3:0] reg_f);
      return ((as_f == 2'b01) && (reg_f != 4'd3)) ||
             ((as_f == 2'b11) && (reg_f == 4'd0));
   endfunction

endpackage

// File: rtl/pc_fetch_seq_ext_word_count.sv
// Combinational decode of how many extension words follow an instruction
// word, and whether the first of them belongs to the source operand.
module ext_word_count
   import pc_fetch_seq_pkg::*;
(
   input  logic [15:0] ir_i,
   output logic [1:0]  cnt_o,
   output logic        src_ext_o
);

   // The byte/word flag has no influence on operand length.
   logic unused_bw;
   assign unused_bw = ir_i[6];

   // Double-operand uses src in [11:8] and Ad in [7]; single-operand keeps
   // its only register in [3:0]; jumps and everything else carry no words.
   always_comb begin
      cnt_o     = 2'd0;
      src_ext_o = 1'b0;
      if (ir_i[15:12] >= 4'd4) begin
         src_ext_o = src_ext_rule(ir_i[5:4], ir_i[11:8]);
         cnt_o     = {1'b0, src_ext_o} + {1'b0, ir_i[7]};
      end else if (ir_i[15:10] == 6'b000100) begin
         src_ext_o = src_ext_rule(ir_i[5:4], ir_i[3:0]);
         cnt_o     = {1'b0, src_ext_o};
      end
   end

endmodule

// File: rtl/pc_fetch_seq.sv
// Instruction fetch sequencer: reads the opcode word at the PC, then any
// extension words, steering the PC mux forward after every accepted read,
// and pulses ir_valid once the full instruction is captured.
module pc_fetch_seq
   import pc_fetch_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] reg_PC_out,
   input  logic [15:0] MDB_in,
   input  logic        mem_ready,
   input  logic        fetch_en,
   input  logic        jump_req,
   output logic [2:0]  MPC,
   output logic [15:0] MAB,
   output logic        mem_rd,
   output logic [15:0] IR,
   output logic [15:0] ext_src,
   output logic [15:0] ext_dst,
   output logic [1:0]  ext_cnt,
   output logic        ir_valid,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        src_flag_q, src_flag_d;
   logic        ext_idx_q, ext_idx_d;

   logic [1:0]  dec_cnt;
   logic        dec_src;
   logic        ext_last;

   // Decode straight off the bus so the count is known in the capture cycle.
   ext_word_count u_ext_word_count (
      .ir_i      (MDB_in),
      .cnt_o     (dec_cnt),
      .src_ext_o (dec_src)
   );

   // The second word is always last; the first is last when only one exists.
   assign ext_last = ext_idx_q | (cnt_q == 2'd1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a jump request in IDLE wins over a fetch request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!jump_req && fetch_en) state_d = ST_FETCH;
         ST_FETCH: if (mem_ready) state_d = (dec_cnt != 2'd0) ? ST_EXT : ST_DONE;
         ST_EXT:   if (mem_ready && ext_last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs; wait states keep the read strobe up with the PC mux holding.
   always_comb begin
      mem_rd   = (state_q == ST_FETCH) || (state_q == ST_EXT);
      ir_valid = (state_q == ST_DONE);
      busy     = (state_q != ST_IDLE);
      MAB      = mem_rd ? (reg_PC_out & 16'hFFFE) : 16'h0000;
      MPC      = MPC_HOLD;
      if (state_q == ST_IDLE && jump_req) MPC = MPC_CALC;
      else if (mem_rd && mem_ready)       MPC = MPC_INC;
   end

   // Capture of opcode and extension words on each accepted read.
   always_comb begin
      ir_d       = ir_q;
      src_d      = src_q;
      dst_d      = dst_q;
      cnt_d      = cnt_q;
      src_flag_d = src_flag_q;
      ext_idx_d  = ext_idx_q;
      if (state_q == ST_FETCH && mem_ready) begin
         ir_d       = MDB_in;
         cnt_d      = dec_cnt;
         src_flag_d = dec_src;
         ext_idx_d  = 1'b0;
      end else if (state_q == ST_EXT && mem_ready) begin
         if (!ext_idx_q && src_flag_q) src_d = MDB_in;
         else                          dst_d = MDB_in;
         ext_idx_d = 1'b1;
      end
   end

   // Instruction registers; cleared by reset, otherwise held between captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q       <= 16'h0000;
         src_q      <= 16'h0000;
         dst_q      <= 16'h0000;
         cnt_q      <= 2'd0;
         src_flag_q <= 1'b0;
         ext_idx_q  <= 1'b0;
      end else begin
         ir_q       <= ir_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         cnt_q      <= cnt_d;
         src_flag_q <= src_flag_d;
         ext_idx_q  <= ext_idx_d;
      end
   end

   assign IR      = ir_q;
   assign ext_src = src_q;
   assign ext_dst = dst_q;
   assign ext_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Testbench for pc_fetch_seq: directed and randomized fetches against a
// timeline model of the fetch sequence and an operand-length model.
module tb_pc_fetch_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] reg_PC_out = 16'h0000;
   logic [15:0] MDB_in = 16'h0000;
   logic        mem_ready = 1'b0;
   logic        fetch_en = 1'b0;
   logic        jump_req = 1'b0;
   logic [2:0]  MPC;
   logic [15:0] MAB;
   logic        mem_rd;
   logic [15:0] IR;
   logic [15:0] ext_src;
   logic [15:0] ext_dst;
   logic [1:0]  ext_cnt;
   logic        ir_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_ir = 16'h0000;
   logic [15:0] m_src = 16'h0000;
   logic [15:0] m_dst = 16'h0000;
   logic [1:0]  m_cnt = 2'd0;

   pc_fetch_seq dut (
      .clk        (clk),
      .rst        (rst),
      .reg_PC_out (reg_PC_out),
      .MDB_in     (MDB_in),
      .mem_ready  (mem_ready),
      .fetch_en   (fetch_en),
      .jump_req   (jump_req),
      .MPC        (MPC),
      .MAB        (MAB),
      .mem_rd     (mem_rd),
      .IR         (IR),
      .ext_src    (ext_src),
      .ext_dst    (ext_dst),
      .ext_cnt    (ext_cnt),
      .ir_valid   (ir_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Operand-length rules computed arithmetically from the instruction word.
   function automatic void model_ext(input logic [15:0] w, output int cnt, output bit sf);
      int v, op, sreg, ad, as_f, dreg;
      v    = int'(w);
      op   = v / 4096;
      sreg = (v / 256) % 16;
      ad   = (v / 128) % 2;
      as_f = (v / 16) % 4;
      dreg = v % 16;
      cnt  = 0;
      sf   = 1'b0;
      if (op >= 4) begin
         sf  = ((as_f == 1) && (sreg != 3)) || ((as_f == 3) && (sreg == 0));
         cnt = int'(sf) + ad;
      end else if (v / 1024 == 4) begin
         sf  = ((as_f == 1) && (dreg != 3)) || ((as_f == 3) && (dreg == 0));
         cnt = int'(sf);
      end
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_MPC"},      16'(MPC), 16'h0);
      chk({tag, "_MAB"},      MAB, 16'h0);
      chk({tag, "_mem_rd"},   16'(mem_rd), 16'h0);
      chk({tag, "_IR"},       IR, 16'h0);
      chk({tag, "_ext_src"},  ext_src, 16'h0);
      chk({tag, "_ext_dst"},  ext_dst, 16'h0);
      chk({tag, "_ext_cnt"},  16'(ext_cnt), 16'h0);
      chk({tag, "_ir_valid"}, 16'(ir_valid), 16'h0);
      chk({tag, "_busy"},     16'(busy), 16'h0);
   endtask

   // One complete fetch, entered 1 time unit after a rising edge with the
   // sequencer idle. Cycle t=0 is the cycle fetch_en is sampled; each read
   // takes waits+1 cycles, and ir_valid follows the last read.
   task automatic run_txn(input logic [15:0] instr, input logic [15:0] e0,
                          input logic [15:0] e1, input int waits,
                          input logic [15:0] pc);
      int cnt, per, T, k;
      bit sf, in_rd, rdy_slot;
      logic [15:0] words [3];
      model_ext(instr, cnt, sf);
      words[0] = instr;
      words[1] = e0;
      words[2] = e1;
      per = waits + 1;
      T   = (1 + cnt) * per + 1;
      reg_PC_out = pc;
      for (int t = 0; t <= T + 1; t++) begin
         in_rd    = (t >= 1) && (t <= T - 1);
         rdy_slot = in_rd && (((t - 1) % per) == waits);
         k        = in_rd ? (t - 1) / per : 0;
         fetch_en  = (t == 0) ? 1'b1 : ((t <= T) ? 1'($urandom_range(1, 0)) : 1'b0);
         jump_req  = (t >= 1 && t <= T) ? 1'($urandom_range(1, 0)) : 1'b0;
         mem_ready = in_rd ? rdy_slot : 1'($urandom_range(1, 0));
         MDB_in    = rdy_slot ? words[k] : 16'($urandom);
         @(negedge clk);
         chk("busy",     16'(busy),     16'(t >= 1 && t <= T));
         chk("mem_rd",   16'(mem_rd),   16'(in_rd));
         chk("MAB",      MAB,           in_rd ? (pc & 16'hFFFE) : 16'h0000);
         chk("MPC",      16'(MPC),      rdy_slot ? 16'd1 : 16'd0);
         chk("ir_valid", 16'(ir_valid), 16'(t == T));
         @(posedge clk);
         #1;
      end
      fetch_en = 1'b0;
      jump_req = 1'b0;
      m_ir  = instr;
      m_cnt = 2'(cnt);
      if (cnt >= 1) begin
         if (sf) m_src = e0;
         else    m_dst = e0;
      end
      if (cnt == 2) m_dst = e1;
      chk("IR",      IR,            m_ir);
      chk("ext_cnt", 16'(ext_cnt),  16'(m_cnt));
      chk("ext_src", ext_src,       m_src);
      chk("ext_dst", ext_dst,       m_dst);
   endtask

   initial begin
      logic [15:0] instr;
      int sel;

      // Reset state
      #2 rst = 1'b1;
      #1 chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed fetches
      run_txn(16'h4506, 16'hAAAA, 16'hBBBB, 0, 16'h1000);
      run_txn(16'h4036, 16'h1234, 16'hCCCC, 0, 16'h2002);
      run_txn(16'h4292, 16'h0200, 16'h0202, 2, 16'h3000);
      run_txn(16'h4316, 16'h5555, 16'h6666, 0, 16'h3010);
      run_txn(16'h3C05, 16'h7777, 16'h8888, 1, 16'h3020);
      run_txn(16'h1290, 16'h0042, 16'h9999, 1, 16'h0101);
      run_txn(16'h1230, 16'hBEEF, 16'h9999, 0, 16'h4444);
      run_txn(16'h4592, 16'hD00D, 16'h9999, 3, 16'h5001);

      // Jump request has priority over fetch in IDLE
      jump_req  = 1'b1;
      fetch_en  = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("jump_MPC",    16'(MPC),    16'd2);
      chk("jump_mem_rd", 16'(mem_rd), 16'd0);
      chk("jump_busy",   16'(busy),   16'd0);
      @(posedge clk); #1;
      jump_req  = 1'b0;
      fetch_en  = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("post_jump_MPC",    16'(MPC),    16'd0);
      chk("post_jump_mem_rd", 16'(mem_rd), 16'd0);
      chk("post_jump_busy",   16'(busy),   16'd0);
      @(posedge clk); #1;

      // Reset in the middle of extension fetch
      reg_PC_out = 16'h0101;
      fetch_en   = 1'b1;
      @(posedge clk); #1;
      fetch_en  = 1'b0;
      mem_ready = 1'b1;
      MDB_in    = 16'h4292;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
      chk("mid_busy",   16'(busy),   16'd1);
      chk("mid_mem_rd", 16'(mem_rd), 16'd1);
      chk("mid_MAB",    MAB,         16'h0100);
      chk("mid_IR",     IR,          16'h4292);
      rst = 1'b1;
      #1 chk_all_zero("abort");
      m_ir  = 16'h0000;
      m_src = 16'h0000;
      m_dst = 16'h0000;
      m_cnt = 2'd0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'($urandom_range(1, 0));
         @(negedge clk);
         chk("abort_ir_valid", 16'(ir_valid), 16'd0);
         chk("abort_busy",     16'(busy),     16'd0);
      end
      @(posedge clk); #1;

      // Randomized fetches
      for (int n = 0; n < 30; n++) begin
         instr = 16'($urandom);
         sel   = $urandom_range(3, 0);
         if (sel == 1)      instr[15] = 1'b1;
         else if (sel == 2) instr[15:10] = 6'b000100;
         else if (sel == 3) instr[15:13] = 3'b001;
         if ($urandom_range(1, 0) == 1) instr[5:4] = 2'($urandom_range(3, 0) | 1);
         run_txn(instr, 16'($urandom), 16'($urandom), $urandom_range(3, 0), 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
